// File: rtl/addsub_rr_arbiter_pkg.sv
// Shared types for the two-requester add/subtract arbiter.
// Contents: FSM state enum, datapath width, captured-operand struct.
package addsub_arb_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Operation latched at the request handshake.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sub;
    logic              id;
  } operand_t;

endpackage

// File: rtl/addsub_rr_arbiter_if.sv
// Request/response bundle between the ALU-issue logic and the shared adder arbiter.
// master: requesters + response consumer.  slave: the arbiter.
//   req{0,1}_valid/_a/_b/_sub -> arbiter, req{0,1}_ready <- arbiter (combinational)
//   rsp_valid/_id/_sum/_cout/_v <- arbiter (registered), rsp_ready -> arbiter
interface addsub_rr_arbiter_if;
  import addsub_arb_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_sub;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_sum;
  logic              rsp_cout;
  logic              rsp_v;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_v
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_v
  );

endinterface

// File: rtl/addsub32.sv
// 32-bit ripple-carry add/subtract.
// Ports: i_a, i_b operands; i_sub selects A-B; o_sum result; o_cout raw carry
// (1 = no borrow on subtract); o_v signed overflow.
module addsub32
  import addsub_arb_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_cout,
  output logic              o_v
);

  logic [DATA_W-1:0] w_bx;
  logic              w_c;
  logic              w_c_msb;

  assign w_bx = i_b ^ {DATA_W{i_sub}};

  // Carry ripples bit by bit; overflow is carry-in vs carry-out of the MSB.
  always_comb begin
    w_c     = i_sub;
    w_c_msb = 1'b0;
    o_sum   = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      o_sum[i] = i_a[i] ^ w_bx[i] ^ w_c;
      if (i == int'(DATA_W) - 1) w_c_msb = w_c;
      w_c = (i_a[i] & w_bx[i]) | (w_c & (i_a[i] ^ w_bx[i]));
    end
  end

  assign o_cout = w_c;
  assign o_v    = w_c ^ w_c_msb;

endmodule

// File: rtl/addsub_rr_arbiter_rr_arb2.sv
// Two-input round-robin grant.
// Ports: i_valid0/i_valid1 requests; i_rr_ptr favoured requester;
// o_grant_c requester id granted (meaningful only when that requester is valid).
module rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_rr_ptr,
  output logic o_grant_c
);

  // Favoured side wins if valid, otherwise fall over to the other side.
  assign o_grant_c = i_rr_ptr ? (i_valid1 ? 1'b1 : 1'b0)
                              : (i_valid0 ? 1'b0 : 1'b1);

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sharing one addsub32 between two requesters.
// Operands are latched at the handshake, held on the adder for SETTLE_CYCLES,
// then the result is registered onto a single id-tagged response channel.
// Ports: clk, rst (sync, active-high); bus (addsub_rr_arbiter_if.slave);
//        ovf_cnt[15:0] saturating count of overflowing responses, present
//        only when ADDSUB_OVF_CNT_EN is defined.
module addsub_rr_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic                clk,
  input  logic                rst,
  addsub_rr_arbiter_if.slave  bus
`ifdef ADDSUB_OVF_CNT_EN
  ,
  output logic [15:0]         ovf_cnt
`endif
);
  import addsub_arb_pkg::*;

  state_t            r_state;
  logic              r_rr_ptr;
  logic [CNT_W-1:0]  r_cnt;
  operand_t          r_op;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_sum;
  logic              r_rsp_cout;
  logic              r_rsp_v;

  logic              w_grant;
  logic              w_ready0;
  logic              w_ready1;
  logic [DATA_W-1:0] w_sum;
  logic              w_cout;
  logic              w_v;

  rr_arb2 u_rr_arb2 (
    .i_valid0  (bus.req0_valid),
    .i_valid1  (bus.req1_valid),
    .i_rr_ptr  (r_rr_ptr),
    .o_grant_c (w_grant)
  );

  // Adder sees only the latched operands, never live requester inputs.
  addsub32 u_addsub32 (
    .i_a    (r_op.a),
    .i_b    (r_op.b),
    .i_sub  (r_op.sub),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_v    (w_v)
  );

  // Readys are suppressed while rst is high so nothing is accepted during reset.
  assign w_ready0 = !rst && (r_state == IDLE) && !w_grant && bus.req0_valid;
  assign w_ready1 = !rst && (r_state == IDLE) &&  w_grant && bus.req1_valid;

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_sum    = r_rsp_sum;
  assign bus.rsp_cout   = r_rsp_cout;
  assign bus.rsp_v      = r_rsp_v;

`ifdef ADDSUB_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;
  assign ovf_cnt = r_ovf_cnt;
`endif

  // Control FSM, operand capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 1'b0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_v     <= 1'b0;
`ifdef ADDSUB_OVF_CNT_EN
      r_ovf_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ready0) begin
            r_op.a   <= bus.req0_a;
            r_op.b   <= bus.req0_b;
            r_op.sub <= bus.req0_sub;
            r_op.id  <= 1'b0;
            r_cnt    <= CNT_W'(SETTLE_CYCLES - 1);
            r_state  <= SETTLE;
          end else if (w_ready1) begin
            r_op.a   <= bus.req1_a;
            r_op.b   <= bus.req1_b;
            r_op.sub <= bus.req1_sub;
            r_op.id  <= 1'b1;
            r_cnt    <= CNT_W'(SETTLE_CYCLES - 1);
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            r_rsp_sum   <= w_sum;
            r_rsp_cout  <= w_cout;
            r_rsp_v     <= w_v;
            r_rsp_id    <= r_op.id;
            r_rsp_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr_ptr    <= ~r_rsp_id;
            r_state     <= IDLE;
`ifdef ADDSUB_OVF_CNT_EN
            if (r_rsp_v && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Scoreboard bench for addsub_rr_arbiter: a negedge monitor pushes the
// expected result at each request handshake and pops/compares it at each
// response handshake; scenario tasks add directed checks.
module tb_addsub_rr_arbiter;
  import addsub_arb_pkg::*;

  localparam int unsigned SETTLE = 2;

  typedef struct {
    logic        id;
    logic [31:0] sum;
    logic        cout;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addsub_rr_arbiter_if bus ();

`ifdef ADDSUB_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  addsub_rr_arbiter #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ADDSUB_OVF_CNT_EN
    ,
    .ovf_cnt (ovf_cnt)
`endif
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   hs_cyc = 0;
  exp_t sb[$];
  int   grant_id[$];
  int   grant_cyc[$];
  logic prev_rsp_valid = 1'b0;
  exp_t mon_e;
  logic        last_id;
  logic [31:0] last_sum;
  logic        last_cout;
  logic        last_v;

  function automatic exp_t model(input logic id, input logic [31:0] a,
                                 input logic [31:0] b, input logic sub);
    exp_t        m;
    logic [31:0] bb;
    logic [32:0] full;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + 33'(sub);
    m.id   = id;
    m.sum  = full[31:0];
    m.cout = full[32];
    m.v    = (a[31] == bb[31]) && (full[31] != a[31]);
    return m;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req0_ready || bus.req1_ready) begin
        n_cmp++;
        if (bus.req0_ready && bus.req1_ready) begin
          n_err++;
          $display("FAIL one_ready cyc=%0d got both readys high, want at most one", cyc);
        end
      end
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_sub));
        grant_id.push_back(0);
        grant_cyc.push_back(cyc);
        hs_cyc = cyc;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_sub));
        grant_id.push_back(1);
        grant_cyc.push_back(cyc);
        hs_cyc = cyc;
      end
      if (bus.rsp_valid && !prev_rsp_valid) begin
        n_cmp++;
        if (cyc - hs_cyc != int'(SETTLE) + 1) begin
          n_err++;
          $display("FAIL latency got=%0d want=%0d", cyc - hs_cyc, int'(SETTLE) + 1);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        last_id   = bus.rsp_id;
        last_sum  = bus.rsp_sum;
        last_cout = bus.rsp_cout;
        last_v    = bus.rsp_v;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rsp id=%0d sum=%h with empty scoreboard", bus.rsp_id, bus.rsp_sum);
        end else begin
          mon_e = sb.pop_front();
          if ({bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_v} !==
              {mon_e.id, mon_e.sum, mon_e.cout, mon_e.v}) begin
            n_err++;
            $display("FAIL rsp got id=%0d sum=%h cout=%0d v=%0d want id=%0d sum=%h cout=%0d v=%0d",
                     bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_v,
                     mon_e.id, mon_e.sum, mon_e.cout, mon_e.v);
          end
        end
      end
    end
    prev_rsp_valid = rst ? 1'b0 : bus.rsp_valid;
  end

  task automatic set_req(input logic id, input logic valid, input logic [31:0] a,
                         input logic [31:0] b, input logic sub);
    if (id == 1'b0) begin
      bus.req0_valid = valid; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
    end else begin
      bus.req1_valid = valid; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
    end
  endtask

  // Drive one request and hold it until accepted (call at posedge+1).
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic sub);
    int k;
    k = 0;
    set_req(id, 1'b1, a, b, sub);
    forever begin
      @(negedge clk);
      if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) break;
      k++;
      if (k > 50) begin
        n_cmp++; n_err++;
        $display("FAIL issue_timeout id=%0d not accepted within 50 cycles", id);
        break;
      end
    end
    @(posedge clk); #1;
    set_req(id, 1'b0, a, b, sub);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending responses, want 0", sb.size());
    end
  endtask

  task automatic check_last(input string name, input logic id, input logic [31:0] sum,
                            input logic cout, input logic v);
    n_cmp++;
    if ({last_id, last_sum, last_cout, last_v} !== {id, sum, cout, v}) begin
      n_err++;
      $display("FAIL %s got id=%0d sum=%h cout=%0d v=%0d want id=%0d sum=%h cout=%0d v=%0d",
               name, last_id, last_sum, last_cout, last_v, id, sum, cout, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    set_req(1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ready got=%b want=00", {bus.req0_ready, bus.req1_ready});
    end
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_v} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_rsp got valid=%0d id=%0d sum=%h cout=%0d v=%0d want all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_v);
    end
`ifdef ADDSUB_OVF_CNT_EN
    n_cmp++;
    if (ovf_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_ovf_cnt got=%0d want=0", ovf_cnt);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_priority got r0r1=%b want=10", {bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_add();
    bus.rsp_ready = 1'b1;
    issue(1'b0, 32'h7B5E4C6A, 32'h1CCDA1E4, 1'b0);
    drain();
    check_last("add_ovf", 1'b0, 32'h982BEE4E, 1'b0, 1'b1);
    issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    drain();
    check_last("add_carry", 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0);
  endtask

  task automatic test_sub();
    bus.rsp_ready = 1'b1;
    issue(1'b0, 32'h00000005, 32'h00000007, 1'b1);
    drain();
    check_last("sub_borrow", 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    issue(1'b1, 32'h80000000, 32'h00000001, 1'b1);
    drain();
    check_last("sub_ovf", 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
`ifdef ADDSUB_OVF_CNT_EN
    n_cmp++;
    if (ovf_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL ovf_cnt got=%0d want=2", ovf_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int k;
    bus.rsp_ready = 1'b1;
    grant_id.delete();
    grant_cyc.delete();
    set_req(1'b0, 1'b1, 32'd1, 32'd2, 1'b0);
    set_req(1'b1, 1'b1, 32'd10, 32'd3, 1'b1);
    k = 0;
    while (grant_id.size() < 6 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    set_req(1'b0, 1'b0, 32'd1, 32'd2, 1'b0);
    set_req(1'b1, 1'b0, 32'd10, 32'd3, 1'b1);
    n_cmp++;
    if (grant_id.size() < 6) begin
      n_err++;
      $display("FAIL b2b_grants got=%0d want>=6", grant_id.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        n_cmp++;
        if (grant_id[i] == grant_id[i-1] || grant_cyc[i] - grant_cyc[i-1] != int'(SETTLE) + 2) begin
          n_err++;
          $display("FAIL b2b_alternate idx=%0d got id=%0d gap=%0d want id!=%0d gap=%0d",
                   i, grant_id[i], grant_cyc[i] - grant_cyc[i-1], grant_id[i-1], int'(SETTLE) + 2);
        end
      end
    end
    drain();
  endtask

  task automatic test_hold_backpressure();
    int k;
    bus.rsp_ready = 1'b0;
    issue(1'b1, 32'h12345678, 32'h11111111, 1'b0);
    set_req(1'b0, 1'b1, 32'd3, 32'd4, 1'b0);
    k = 0;
    @(negedge clk);
    while (!bus.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_v,
           bus.req0_ready, bus.req1_ready} !== {1'b1, 1'b1, 32'h23456789, 1'b0, 1'b0, 2'b00}) begin
        n_err++;
        $display("FAIL hold_stable i=%0d got valid=%0d id=%0d sum=%h cout=%0d v=%0d r0r1=%b want 1 1 23456789 0 0 00",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_v,
                 {bus.req0_ready, bus.req1_ready});
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.rsp_valid, bus.req0_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL hold_release got rsp_valid=%0d req0_ready=%0d want 0 1",
               bus.rsp_valid, bus.req0_ready);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'd3, 32'd4, 1'b0);
    drain();
    check_last("hold_next", 1'b0, 32'd7, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_settle();
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 32'h40000000, 32'h40000000, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_accept got req0_ready=%0d want 1", bus.req0_ready);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'h40000000, 32'h40000000, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    if (sb.size() != 0) void'(sb.pop_back());
    set_req(1'b0, 1'b1, 32'd5, 32'd6, 1'b0);
    set_req(1'b1, 1'b1, 32'd9, 32'd1, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL mid_rst_ready got=%b want=00", {bus.req0_ready, bus.req1_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b010) begin
      n_err++;
      $display("FAIL mid_after_rst got valid=%0d r0r1=%b want 0 10",
               bus.rsp_valid, {bus.req0_ready, bus.req1_ready});
    end
`ifdef ADDSUB_OVF_CNT_EN
    n_cmp++;
    if (ovf_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL mid_ovf_cnt got=%0d want=0", ovf_cnt);
    end
`endif
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 32'd5, 32'd6, 1'b0);
    set_req(1'b1, 1'b0, 32'd9, 32'd1, 1'b0);
    drain();
    check_last("mid_fresh", 1'b0, 32'd11, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_hold_backpressure();
    test_reset_mid_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
